sample_capture_wb: RTL and testbench

Wishbone-readable capture buffer that sits directly downstream of the FM generator slave. It records a run of signed generator samples into on-chip RAM on a host "arm" command. The host then reads the run back through the hbbus/UART bridge for waveform inspection. It shares the generator's clock and bus, and decodes its own page of the address map.

---
 rtl/sample_capture_wb_pkg.sv | 17 +
 rtl/sample_capture_wb_capture_ram.sv | 20 ++
 rtl/sample_capture_wb.sv | 141 ++++++++++++++
 tb/tb_sample_capture_wb.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sample_capture_wb_pkg.sv
// sample_capture_wb_pkg: shared constants for the capture buffer.
// Holds the register map, the CTRL/STATUS bit positions and the FSM state encoding.
package sample_capture_wb_pkg;
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LENGTH = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_DECIM  = 2'd3;
    localparam int CTRL_ARM       = 0;
    localparam int CTRL_ABORT     = 1;
    localparam int STAT_CAPTURING = 0;
    localparam int STAT_DONE      = 1;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;
endpackage

// File: rtl/sample_capture_wb_capture_ram.sv
// capture_ram: single-clock RAM, one synchronous write port and one synchronous read port.
// Ports: i_clk; i_we/i_waddr/i_wdata write port; i_raddr read address; o_rdata read data one cycle later.
// Contents are deliberately not reset so the array maps onto block RAM.
module capture_ram #(
    parameter int width      = 17,
    parameter int depth_log2 = 10
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [depth_log2-1:0] i_waddr,
    input  logic [width-1:0]      i_wdata,
    input  logic [depth_log2-1:0] i_raddr,
    output logic [width-1:0]      o_rdata
);
    logic [width-1:0] r_mem [2**depth_log2];
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/sample_capture_wb.sv
// sample_capture_wb: Wishbone-readable capture buffer for signed generator samples.
// Ports: i_clk, i_resetb (async active-low); i_sample/i_sample_stb sample stream;
// i_wb_* / o_wb_* pipelined Wishbone slave (ack 2 cycles after each strobe, never stalls);
// o_done high while a finished capture is held.
// Optional feature: define CAPTURE_DECIMATE_EN to add the DECIM register and strobe decimation.
module sample_capture_wb
    import sample_capture_wb_pkg::*;
#(
    parameter int sample_width = 17,
    parameter int depth_log2   = 10
) (
    input  logic                    i_clk,
    input  logic                    i_resetb,
    input  logic [sample_width-1:0] i_sample,
    input  logic                    i_sample_stb,
    input  logic                    i_wb_cyc,
    input  logic                    i_wb_stb,
    input  logic                    i_wb_we,
    input  logic [depth_log2:0]     i_wb_addr,
    input  logic [31:0]             i_wb_data,
    output logic                    o_wb_ack,
    output logic                    o_wb_stall,
    output logic [31:0]             o_wb_data,
    output logic                    o_done
);
    state_t                  r_state;
    logic [depth_log2-1:0]   r_ptr;
    logic [depth_log2-1:0]   r_length;
    logic [depth_log2:0]     r_count;
    logic                    r_req_vld;
    logic                    r_req_buf;
    logic [1:0]              r_req_reg;
    logic                    r_ack;
    logic [31:0]             r_rd_data;
    logic                    w_req;
    logic                    w_reg_wr;
    logic                    w_ctrl_wr;
    logic                    w_arm;
    logic                    w_abort;
    logic                    w_accept;
    logic                    w_ram_we;
    logic [sample_width-1:0] w_rdata;
    logic [31:0]             w_status;
    logic [31:0]             w_decim_rd;
    logic [31:0]             w_reg_rdata;
    logic                    w_unused;

    assign w_unused  = ^i_wb_data;
    assign w_req     = i_wb_cyc & i_wb_stb;
    assign w_reg_wr  = w_req & i_wb_we & ~i_wb_addr[depth_log2];
    assign w_ctrl_wr = w_reg_wr && i_wb_addr[1:0] == REG_CTRL;
    assign w_arm     = w_ctrl_wr & i_wb_data[CTRL_ARM];
    assign w_abort   = w_ctrl_wr & i_wb_data[CTRL_ABORT];
    // A control write in the same cycle pre-empts the sample, so the arm cycle never captures.
    assign w_ram_we  = r_state == CAPTURE && w_accept && !w_arm && !w_abort;

`ifdef CAPTURE_DECIMATE_EN
    logic [15:0] r_decim;
    logic [15:0] r_dec_cnt;
    assign w_accept   = i_sample_stb && r_dec_cnt == 16'd0;
    assign w_decim_rd = 32'(r_decim);
    // Counter cleared on arm so the first strobe afterwards is always taken.
    always_ff @(posedge i_clk or negedge i_resetb) begin
        if (!i_resetb) begin
            r_decim   <= '0;
            r_dec_cnt <= '0;
        end else begin
            if (w_reg_wr && i_wb_addr[1:0] == REG_DECIM) r_decim <= i_wb_data[15:0];
            if (w_arm) r_dec_cnt <= '0;
            else if (i_sample_stb) r_dec_cnt <= r_dec_cnt >= r_decim ? '0 : r_dec_cnt + 16'd1;
        end
    end
`else
    assign w_accept   = i_sample_stb;
    assign w_decim_rd = '0;
`endif

    capture_ram #(.width(sample_width), .depth_log2(depth_log2)) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_ram_we),
        .i_waddr (r_ptr),
        .i_wdata (i_sample),
        .i_raddr (i_wb_addr[depth_log2-1:0]),
        .o_rdata (w_rdata)
    );

    // Abort has priority over arm; the last write (ptr==LENGTH) ends the run and ptr holds there.
    always_ff @(posedge i_clk or negedge i_resetb) begin
        if (!i_resetb) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_count  <= '0;
            r_length <= '1;
        end else begin
            if (w_reg_wr && i_wb_addr[1:0] == REG_LENGTH && r_state != CAPTURE)
                r_length <= i_wb_data[depth_log2-1:0];
            if (w_abort) begin
                r_state <= IDLE;
            end else if (w_arm) begin
                r_state <= CAPTURE;
                r_ptr   <= '0;
                r_count <= '0;
            end else if (w_ram_we) begin
                r_count <= r_count + 1'b1;
                r_ptr   <= r_ptr == r_length ? r_ptr : r_ptr + 1'b1;
                if (r_ptr == r_length) r_state <= DONE;
            end
        end
    end

    always_comb begin
        w_status                 = '0;
        w_status[STAT_CAPTURING] = r_state == CAPTURE;
        w_status[STAT_DONE]      = r_state == DONE;
        w_reg_rdata = r_req_reg == REG_CTRL   ? w_status :
                      r_req_reg == REG_LENGTH ? 32'(r_length) :
                      r_req_reg == REG_COUNT  ? 32'(r_count) : w_decim_rd;
    end

    // Stage 1 waits for the synchronous RAM read; stage 2 registers ack and data together.
    always_ff @(posedge i_clk or negedge i_resetb) begin
        if (!i_resetb) begin
            r_req_vld <= 1'b0;
            r_req_buf <= 1'b0;
            r_req_reg <= '0;
            r_ack     <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_req_vld <= w_req;
            r_req_buf <= i_wb_addr[depth_log2];
            r_req_reg <= i_wb_addr[1:0];
            r_ack     <= r_req_vld;
            r_rd_data <= !r_req_vld ? '0 : r_req_buf ? 32'($signed(w_rdata)) : w_reg_rdata;
        end
    end

    assign o_wb_ack   = r_ack;
    assign o_wb_data  = r_rd_data;
    assign o_wb_stall = 1'b0;
    assign o_done     = r_state == DONE;
endmodule

// File: tb/tb_sample_capture_wb.sv
// tb_sample_capture_wb: scoreboard bench for sample_capture_wb; reads push expectations, a monitor checks acks.
module tb_sample_capture_wb;
    logic        clk = 1'b0;
    logic        i_resetb = 1'b0;
    logic [16:0] i_sample = '0;
    logic        i_sample_stb = 1'b0;
    logic        i_wb_cyc = 1'b0;
    logic        i_wb_stb = 1'b0;
    logic        i_wb_we = 1'b0;
    logic [10:0] i_wb_addr = '0;
    logic [31:0] i_wb_data = '0;
    logic        o_wb_ack;
    logic        o_wb_stall;
    logic [31:0] o_wb_data;
    logic        o_done;

    typedef struct {
        int          cyc;
        bit          chk;
        logic [31:0] exp;
        string       nm;
    } ent_t;

    ent_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    sample_capture_wb dut (
        .i_clk        (clk),
        .i_resetb     (i_resetb),
        .i_sample     (i_sample),
        .i_sample_stb (i_sample_stb),
        .i_wb_cyc     (i_wb_cyc),
        .i_wb_stb     (i_wb_stb),
        .i_wb_we      (i_wb_we),
        .i_wb_addr    (i_wb_addr),
        .i_wb_data    (i_wb_data),
        .o_wb_ack     (o_wb_ack),
        .o_wb_stall   (o_wb_stall),
        .o_wb_data    (o_wb_data),
        .o_done       (o_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (i_resetb && o_wb_ack) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL spurious_ack: ack seen at cycle %0d with no request pending", cyc);
            end else begin
                ent_t e;
                e = sb.pop_front();
                if (cyc != e.cyc + 2 || o_wb_stall !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_latency: ack cycle %0d stall %b, required cycle %0d stall 0",
                             e.nm, cyc, o_wb_stall, e.cyc + 2);
                end
                if (e.chk) begin
                    checks++;
                    if (o_wb_data !== e.exp) begin
                        failures++;
                        $display("FAIL %s: got %h required %h", e.nm, o_wb_data, e.exp);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic wb(input logic we, input logic [10:0] a, input logic [31:0] d,
                      input bit c, input logic [31:0] exp, input string nm);
        ent_t e;
        @(posedge clk); #1;
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we; i_wb_addr = a; i_wb_data = d;
        e.cyc = cyc; e.chk = c; e.exp = exp; e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0; i_sample_stb = 1'b0;
    endtask

    task automatic rd(input logic [10:0] a, input logic [31:0] exp, input string nm);
        wb(1'b0, a, 32'd0, 1'b1, exp, nm);
        idle();
    endtask

    task automatic wr(input logic [10:0] a, input logic [31:0] d);
        wb(1'b1, a, d, 1'b0, 32'd0, "wr");
        idle();
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d acks still outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic samp(input int v, input logic exp_done, input string nm);
        @(posedge clk); #1;
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
        i_sample_stb = 1'b1; i_sample = v[16:0];
        @(posedge clk); #1;
        i_sample_stb = 1'b0;
        chk(nm, {31'd0, o_done}, {31'd0, exp_done});
    endtask

    // Arm write with a strobe in the same cycle; that sample must not be captured.
    task automatic arm_pre(input int pre);
        wb(1'b1, 11'h000, 32'd1, 1'b0, 32'd0, "arm");
        i_sample_stb = 1'b1; i_sample = pre[16:0];
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", {31'd0, o_done}, 32'd0);
        chk("rst_ack", {31'd0, o_wb_ack}, 32'd0);
        chk("rst_data", o_wb_data, 32'd0);
        i_resetb = 1'b1;
        rd(11'h001, 32'h3FF, "rst_length");
        rd(11'h000, 32'h0, "rst_ctrl");
        rd(11'h002, 32'h0, "rst_count");
        drain();

        wr(11'h001, 32'd3);
        wr(11'h000, 32'd1);
        rd(11'h000, 32'h1, "ctrl_capturing");
        drain();
        samp(-5, 1'b0, "done_s0");
        samp(7, 1'b0, "done_s1");
        samp(100, 1'b0, "done_s2");
        samp(-1, 1'b1, "done_s3");
        rd(11'h000, 32'h2, "ctrl_done");
        rd(11'h002, 32'd4, "count4");
        wb(1'b0, 11'h400, 32'd0, 1'b1, 32'hFFFFFFFB, "buf0");
        wb(1'b0, 11'h401, 32'd0, 1'b1, 32'h00000007, "buf1");
        wb(1'b0, 11'h402, 32'd0, 1'b1, 32'h00000064, "buf2");
        wb(1'b0, 11'h403, 32'd0, 1'b1, 32'hFFFFFFFF, "buf3");
        idle();
        drain();

        wr(11'h000, 32'd2);
        rd(11'h000, 32'h0, "abort_from_done");
        wr(11'h000, 32'd3);
        rd(11'h000, 32'h0, "arm_abort_idle");
        drain();
        chk("arm_abort_done", {31'd0, o_done}, 32'd0);

        wr(11'h001, 32'd7);
        wr(11'h000, 32'd1);
        samp(11, 1'b0, "part_s0");
        samp(12, 1'b0, "part_s1");
        wr(11'h001, 32'd5);
        wr(11'h000, 32'd2);
        rd(11'h000, 32'h0, "abort_idle");
        rd(11'h002, 32'd2, "abort_count");
        rd(11'h001, 32'd7, "length_locked");
        drain();

        wr(11'h001, 32'd0);
        arm_pre(77);
        samp(42, 1'b1, "len0_done");
        wr(11'h400, 32'd123);
        rd(11'h400, 32'd42, "len0_mem0");
        rd(11'h002, 32'd1, "len0_count");
        drain();

`ifdef CAPTURE_DECIMATE_EN
        wr(11'h003, 32'd2);
        wr(11'h001, 32'd1);
        rd(11'h003, 32'd2, "decim_rd");
        drain();
        arm_pre(99);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
            if (o_done) break;
            i_sample_stb = 1'b1; i_sample = 17'(k);
        end
        i_sample_stb = 1'b0;
        chk("decim_done", {31'd0, o_done}, 32'd1);
        rd(11'h400, 32'd0, "decim_mem0");
        rd(11'h401, 32'd3, "decim_mem1");
        rd(11'h002, 32'd2, "decim_count");
        drain();
        wr(11'h000, 32'd1);
        samp(5, 1'b0, "mid_s0");
        rd(11'h000, 32'h1, "mid_capturing");
        drain();
        #3 i_resetb = 1'b0;
        #1 chk("mid_rst_done", {31'd0, o_done}, 32'd0);
        @(posedge clk); #1 i_resetb = 1'b1;
        rd(11'h000, 32'h0, "mid_rst_ctrl");
        rd(11'h002, 32'h0, "mid_rst_count");
        rd(11'h003, 32'h0, "mid_rst_decim");
        rd(11'h001, 32'h3FF, "mid_rst_length");
        drain();
`else
        wr(11'h003, 32'd5);
        rd(11'h003, 32'd0, "decim_absent");
        drain();
`endif
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
